// File: rtl/niosqs_mem_arb_pkg.sv
// niosqs_mem_arb_pkg
//   Shared definitions for the on-chip RAM arbiter:
//   - requester id constants (REQ_M0 = Nios data master, REQ_M1 = LCD fetch)
//   - default bus widths
//   - pend_stage_t: one stage of the read-return pipeline {valid, id}
package niosqs_mem_arb_pkg;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_BE_W   = DEF_DATA_W / 8;

    typedef struct packed {
        logic valid;
        logic id;
    } pend_stage_t;

endpackage

// File: rtl/niosqs_rr_arb2.sv
// niosqs_rr_arb2
//   Two-way round-robin picker. Purely combinational; the caller holds the
//   last_grant register.
// Ports:
//   req[1:0]        requests from m0 (bit 0) and m1 (bit 1)
//   last_grant      id of the requester that won the previous transfer
//   accept          transfers may be accepted this cycle (out of reset)
//   grant[1:0]      one-hot grant, zero when nobody requests
//   last_grant_nxt  value to load into the last_grant register
module niosqs_rr_arb2
    import niosqs_mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       last_grant_nxt
);

    always_comb begin
        grant          = 2'b00;
        last_grant_nxt = last_grant;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Contention: whoever did not win last time goes now.
            2'b11:   grant = (last_grant == REQ_M1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        if (accept && (grant != 2'b00))
            last_grant_nxt = grant[1];
    end

endmodule

// File: rtl/niosqs_onchip_mem_arbiter.sv
// niosqs_onchip_mem_arbiter
//   Round-robin arbiter between the Nios data master (m0) and the LCD
//   frame/text fetch engine (m1) in front of a single-port on-chip RAM.
//   One transfer per clock; read data is steered back to the issuing
//   requester RD_LATENCY clocks after acceptance.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   m0_* / m1_*           Avalon-MM slave ports (address, byteenable, read,
//                         write, writedata, waitrequest, readdata,
//                         readdatavalid)
//   mem_*                 RAM side: address, byteenable, chipselect, write,
//                         writedata, clken, readdata (RAM q)
// Optional (macro NIOSQS_MEM_ARB_PERF_EN):
//   perf_clear            synchronous clear of the counters
//   perf_grant0/1         accepted transfers per requester (saturating)
//   perf_stall            cycles with a stalled request (saturating)
// RD_LATENCY must be 1 (raw RAM q) or 2 (RAM output register enabled).
module niosqs_onchip_mem_arbiter
    import niosqs_mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int BE_W       = DATA_W / 8,
    parameter int RD_LATENCY = 1
`ifdef NIOSQS_MEM_ARB_PERF_EN
    ,
    parameter int CNT_W      = 32
`endif
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
`ifdef NIOSQS_MEM_ARB_PERF_EN
    ,
    input  logic              perf_clear,
    output logic [CNT_W-1:0]  perf_grant0,
    output logic [CNT_W-1:0]  perf_grant1,
    output logic [CNT_W-1:0]  perf_stall
`endif
);

    logic [1:0]  req;
    logic [1:0]  grant;
    logic        last_grant;
    logic        last_grant_nxt;
    logic        sel_write;
    logic        rd_acc;
    pend_stage_t pend [RD_LATENCY];
    pend_stage_t pend_out;

    // A request with both read and write set is treated as a write.
    assign req = {m1_read | m1_write, m0_read | m0_write};

    niosqs_rr_arb2 u_arb (
        .req            (req),
        .last_grant     (last_grant),
        .accept         (reset_n),
        .grant          (grant),
        .last_grant_nxt (last_grant_nxt)
    );

    // Reset value REQ_M1 makes m0 win the first contention.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last_grant <= REQ_M1;
        else          last_grant <= last_grant_nxt;
    end

    // Waitrequest is forced high while reset is asserted so no master
    // believes a transfer was taken.
    assign m0_waitrequest = ~reset_n | (req[0] & ~grant[0]);
    assign m1_waitrequest = ~reset_n | (req[1] & ~grant[1]);

    // Address/data mux defaults to the m0 leg when nobody is granted.
    always_comb begin
        mem_address    = m0_address;
        mem_writedata  = m0_writedata;
        mem_byteenable = m0_byteenable;
        sel_write      = m0_write;
        if (grant[1]) begin
            mem_address    = m1_address;
            mem_writedata  = m1_writedata;
            mem_byteenable = m1_byteenable;
            sel_write      = m1_write;
        end
        if (!sel_write)
            mem_byteenable = '1;
        mem_chipselect = reset_n & (|grant);
        mem_write      = mem_chipselect & sel_write;
    end

    assign mem_clken = reset_n;
    assign rd_acc    = mem_chipselect & ~sel_write;

    // Read-return pipe: one stage per clock of RAM latency, so the last
    // stage lines up with the cycle the RAM q holds this read's data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LATENCY; i++)
                pend[i] <= '0;
        end else begin
            pend[0] <= '{valid: rd_acc, id: grant[1]};
            for (int i = 1; i < RD_LATENCY; i++)
                pend[i] <= pend[i-1];
        end
    end

    assign pend_out         = pend[RD_LATENCY-1];
    assign m0_readdatavalid = pend_out.valid & (pend_out.id == REQ_M0);
    assign m1_readdatavalid = pend_out.valid & (pend_out.id == REQ_M1);
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

`ifdef NIOSQS_MEM_ARB_PERF_EN
    logic stall;
    assign stall = |(req & ~grant);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_grant0 <= '0;
            perf_grant1 <= '0;
            perf_stall  <= '0;
        end else if (perf_clear) begin
            perf_grant0 <= '0;
            perf_grant1 <= '0;
            perf_stall  <= '0;
        end else begin
            if (grant[0] && (perf_grant0 != '1)) perf_grant0 <= perf_grant0 + CNT_W'(1);
            if (grant[1] && (perf_grant1 != '1)) perf_grant1 <= perf_grant1 + CNT_W'(1);
            if (stall    && (perf_stall  != '1)) perf_stall  <= perf_stall  + CNT_W'(1);
        end
    end
`endif

    // Simultaneous read and write from one master is illegal stimulus.
    a_m0_rw_excl: assert property (@(posedge clk) disable iff (!reset_n) !(m0_read && m0_write));
    a_m1_rw_excl: assert property (@(posedge clk) disable iff (!reset_n) !(m1_read && m1_write));

endmodule

// File: doc/niosqs_onchip_mem_arbiter.md
Name: niosqs_onchip_mem_arbiter

Overview:
- Two-requester Avalon-MM arbiter in front of the single-port on-chip RAM (32-bit data, 16-bit word address, byte enables, 1-cycle read latency with registered address and unregistered q).
- Requester 0 is the Nios data master; requester 1 is the LCD frame/text fetch engine.
- Round-robin grant with fully pipelined back-to-back access.
- Returns read data to the issuing requester with readdatavalid.

Parameters:
- ADDR_W, 16, word address width to the RAM.
- DATA_W, 32, data width.
- BE_W, 4, byte-enable width (DATA_W/8).
- RD_LATENCY, 1, RAM read latency in clocks. Legal values are 1 or 2; 2 is used when the RAM output register is enabled.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m0_address  in  ADDR_W  requester 0 word address
- m0_byteenable  in  BE_W  requester 0 byte enables
- m0_read  in  1  requester 0 read request
- m0_write  in  1  requester 0 write request
- m0_writedata  in  DATA_W  requester 0 write data
- m0_waitrequest  out  1  requester 0 stall
- m0_readdata  out  DATA_W  requester 0 read data
- m0_readdatavalid  out  1  requester 0 read data valid
- m1_*  (same eight signals as m0_*)  requester 1
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  BE_W  to RAM byte enables
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_W  to RAM write data
- mem_clken  out  1  to RAM clken
- mem_readdata  in  DATA_W  from RAM q

Behaviour:
- Request: req_x = mx_read | mx_write. If both read and write are high, the transfer is treated as a write. This is illegal stimulus, flagged by an assertion.
- Arbitration is combinational from the current req_x and a registered last_grant (reset value 1, so m0 wins the first contention).
  - Only one request: it is granted.
  - Both: grant goes to the requester not equal to last_grant.
  - last_grant updates on every accepted transfer.
- Accept: mx_waitrequest = req_x & ~grant_x. When idle, waitrequest = 0. While reset_n = 0, both waitrequests = 1.
- Memory drive in the grant cycle:
  - mem_chipselect = 1; address, byteenable and writedata are muxed from the granted requester; mem_write = granted write.
  - With no grant: chipselect = 0, write = 0, address/data hold the m0 mux leg.
  - mem_byteenable for reads is forced to all-ones.
- mem_clken = 1 out of reset, 0 in reset.
- Read return: pending pipeline of RD_LATENCY stages, each stage {valid, id}, reset to 0.
  - An accepted read pushes {1, id}; a write or idle cycle pushes {0, x}.
  - At the last stage: m<id>_readdatavalid = 1 and m<id>_readdata = mem_readdata.
  - readdata is a combinational pass-through, valid only while readdatavalid is high; readdatavalid is registered timing from the pipe.
  - Read latency seen by the requester = RD_LATENCY cycles after acceptance.
- Throughput: one transfer per cycle. Reads from alternating requesters issue back-to-back with no bubbles. Writes have zero latency, and write-after-read needs no turnaround.
- Reset mid-operation: pending read pipe cleared, so no readdatavalid is produced for reads in flight. last_grant returns to 1. All outputs take their reset values asynchronously.
- Reset values: m*_readdatavalid 0, mem_chipselect 0, mem_write 0, mem_clken 0, waitrequests 1. All other outputs are don't-care in reset.
- Fairness: under continuous dual contention, grants strictly alternate m0, m1, m0, ... Maximum wait per requester is 1 cycle.

Optional Feature:
- Macro: NIOSQS_MEM_ARB_PERF_EN.
- When defined, add outputs perf_grant0 (CNT_W), perf_grant1 (CNT_W) and perf_stall (CNT_W), plus input perf_clear (1).
  - perf_grant0 / perf_grant1 count accepted transfers per requester.
  - perf_stall counts cycles in which any waitrequest = 1 while its req = 1.
  - Counters saturate at all-ones.
  - perf_clear synchronously zeros all three and has priority over increment.
  - Reset value 0.
- When undefined: ports and logic are absent, and the base behaviour is unchanged.

Decomposition:
- Package niosqs_mem_arb_pkg holds:
  - requester id constants REQ_M0 = 0, REQ_M1 = 1;
  - default ADDR_W/DATA_W/BE_W;
  - pend_stage_t struct {valid, id}.
- One sub-module, niosqs_rr_arb2: 2-way round-robin picker (req[1:0], last_grant, accept -> grant[1:0], next last_grant register).
- Datapath muxes and the pending pipe stay in the top level.

Test Plan:
- m0 write addr 0x0010 data 0xDEADBEEF be 0xF, then m0 read 0x0010 -> zero waitrequest; mem_write pulses for 1 cycle; m0_readdatavalid 1 cycle after read acceptance with 0xDEADBEEF; m1_readdatavalid stays 0.
- m0 and m1 both read continuously (addresses 0x0000.. and 0x8000..) for 8 cycles -> grants m0, m1, m0, ...; each waitrequest high on alternate cycles; readdatavalid alternates with correct data and id.
- m1 write be 0x3 data 0x12345678 to 0x0100 over an existing 0xAAAAAAAA, then read -> 0xAAAA5678.
- Read accepted, reset_n pulsed low the next cycle -> no readdatavalid emitted; after release first contention grants m0.
- RD_LATENCY = 2 build: back-to-back reads m0@0x0004, m1@0x0008 -> readdatavalid at +2 cycles each, routed to the correct requester.
- With NIOSQS_MEM_ARB_PERF_EN: 10 dual-contention cycles -> perf_grant0 = 5, perf_grant1 = 5, perf_stall = 10; pulse perf_clear -> all 0.
